sysbus_arbiter: RTL and testbench
=================================

Name: sysbus_arbiter

Overview:
- Shares the single Sysbus port between two requesters: instruction fetch (port 0) and data memory / load-store (port 1).
- Grants one requester at a time with round-robin priority and forwards its request beats to the bus.
- Routes the response beats back to the granted requester. At most one transaction is outstanding at a time.
- Sits between the core's fetch and data engines and the top-level Sysbus. Allows a data-access unit to be added without modifying the fetch logic.

Parameters:
- DATA_W, 64, width of the req/resp data beats
- TAG_W, 13, width of reqtag; bit TAG_W-1 is the op bit (1=WRITE, 0=READ)
- LINE_BEATS, 8, beats per transfer (one 64-byte line); the read response count and the write data-beat count are both this value
- CNT_W, 4, width of the beat counter; must be >= clog2(LINE_BEATS+1)

Ports:
- clk  in  1  bus clock
- reset  in  1  synchronous, active-high reset
- r0_reqcyc  in  1  fetch request valid
- r0_req  in  DATA_W  fetch address or data beat
- r0_reqtag  in  TAG_W  fetch tag
- r0_reqack  out  1  fetch beat accepted
- r0_respcyc  out  1  fetch response beat valid
- r0_resp  out  DATA_W  fetch response data
- r0_respack  in  1  fetch consumed response beat
- r1_reqcyc, r1_req, r1_reqtag, r1_reqack, r1_respcyc, r1_resp, r1_respack: same as port 0, for the data requester
- bus_reqcyc  out  1  to Sysbus reqcyc
- bus_req  out  DATA_W  to Sysbus req
- bus_reqtag  out  TAG_W  to Sysbus reqtag
- bus_reqack  in  1  from Sysbus reqack
- bus_respcyc  in  1  from Sysbus respcyc
- bus_resp  in  DATA_W  from Sysbus resp
- bus_respack  out  1  to Sysbus respack
- owner  out  1  current/last grant (0=fetch, 1=data); debug/perf
- busy  out  1  high in any state other than IDLE

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE, owner=1 (so fetch has priority first), beat_cnt=0, busy=0. All request-side outputs are 0.
- Beat acceptance: a beat transfers on any cycle with reqcyc && reqack.
- Response backpressure:
  - bus_respack = granted r*_respack gated by bus_respcyc.
  - r*_respcyc = bus_respcyc && state==RESP && owner==*.
  - r*_resp = bus_resp (unconditionally wired).
- The non-owner's reqack and respcyc are always 0.
- Request mux (combinational):
  - In REQ/WDATA: bus_reqcyc/bus_req/bus_reqtag = owner's signals; owner's reqack = bus_reqack.
  - In IDLE/RESP: bus_reqcyc=0.
- IDLE:
  - If exactly one r*_reqcyc is high: owner<=that port, go to REQ.
  - If both are high: grant the port != owner (round-robin), go to REQ.
  - The grant takes effect the next cycle. Zero-cycle passthrough is not allowed, so reqack is never asserted in IDLE.
- REQ:
  - Forward the address beat. On the transfer, latch op=reqtag[TAG_W-1] and set beat_cnt=0.
  - WRITE: go to WDATA.
  - READ: go to RESP.
  - If owner drops reqcyc before the transfer: return to IDLE. This is a protocol error; it must not assert on the bus.
- WDATA:
  - Forward the owner's data beats; each transfer increments beat_cnt.
  - After LINE_BEATS transfers: go to IDLE. No response is expected for writes.
- RESP:
  - Each cycle with bus_respcyc && owner's respack increments beat_cnt.
  - On the LINE_BEATS-th beat: go to IDLE the next cycle.
  - bus_respcyc while owner's respack=0: the beat is not counted (held).
- bus_respcyc outside RESP: beat dropped, bus_respack=0, simulation assertion fires.
- Back-to-back: the same requester may be regranted from IDLE only if the other is not requesting. Minimum of one IDLE cycle between transactions.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1...
- Reset mid-transaction: return to IDLE immediately, drop all outputs to 0, discard the counter. Any in-flight bus beats after reset are ignored.
- beat_cnt compares against LINE_BEATS in CNT_W bits and never wraps.

Test Plan:
- Fetch read alone: r0 asserts reqcyc with addr 0x1000.
  - Required: grant next cycle, bus_req=0x1000, 8 resp beats (0xA0..0xA7) delivered only on r0_resp, r1_respcyc=0 throughout, back to IDLE after beat 8.
- Simultaneous requests after reset: r0 and r1 both request.
  - Required: r0 granted first (owner reset=1), r1 granted after r0's 8 beats.
  - Then both requesting again: r0 granted third.
- Data write: r1 issues a WRITE tag, address 0x2040, then 8 data beats 0x11..0x88.
  - Required: all 9 beats appear on the bus in order, no RESP state entered, busy low after the last reqack.
- Response backpressure: r0 read with r0_respack low on beats 3–4.
  - Required: beat_cnt holds, bus_respack=0 on those cycles, exactly 8 counted beats, 10 RESP cycles total.
- Reset in RESP after 4 beats.
  - Required: next cycle state=IDLE, all outputs 0.
  - A new r1 request is then granted normally, and its 8 beats complete.
- Spurious bus_respcyc while IDLE.
  - Required: no r*_respcyc, bus_respack=0, assertion fires.

Source files
------------

// File: rtl/sysbus_arbiter_if.sv
// Sysbus-style request/response beat channel. Requesters hold the master side,
// the arbiter presents the slave side to each requester and the master side to the bus.
interface sysbus_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13
);
    logic              reqcyc;
    logic [DATA_W-1:0] req;
    logic [TAG_W-1:0]  reqtag;
    logic              reqack;
    logic              respcyc;
    logic [DATA_W-1:0] resp;
    logic              respack;

    modport master (output reqcyc, req, reqtag, respack, input reqack, respcyc, resp);
    modport slave  (input reqcyc, req, reqtag, respack, output reqack, respcyc, resp);
endinterface

// File: rtl/sysbus_arbiter.sv
// Two-way round-robin arbiter sharing one Sysbus port between fetch (r0) and
// load/store (r1); one transaction in flight, responses routed to the owner.
module sysbus_arbiter #(
    parameter int DATA_W     = 64,
    parameter int TAG_W      = 13,
    parameter int LINE_BEATS = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    sysbus_arbiter_if.slave  r0,
    sysbus_arbiter_if.slave  r1,
    sysbus_arbiter_if.master bus,
    output logic             owner,
    output logic             busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WDATA = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS);

    logic [1:0]        state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              own_reqcyc;
    logic              own_respack;
    logic [DATA_W-1:0] own_req;
    logic [TAG_W-1:0]  own_tag;
    logic              fwd_phase;
    logic              resp_phase;
    logic              req_xfer;

    assign own_reqcyc  = owner ? r1.reqcyc  : r0.reqcyc;
    assign own_respack = owner ? r1.respack : r0.respack;
    assign own_req     = owner ? r1.req     : r0.req;
    assign own_tag     = owner ? r1.reqtag  : r0.reqtag;

    // Grant only becomes visible the cycle after IDLE, so nothing passes through in IDLE.
    assign fwd_phase  = (state == S_REQ) || (state == S_WDATA);
    assign resp_phase = (state == S_RESP);

    assign bus.reqcyc  = fwd_phase && own_reqcyc;
    assign bus.req     = fwd_phase ? own_req : '0;
    assign bus.reqtag  = fwd_phase ? own_tag : '0;
    assign bus.respack = resp_phase && bus.respcyc && own_respack;

    assign r0.reqack  = fwd_phase && !owner && bus.reqack;
    assign r1.reqack  = fwd_phase &&  owner && bus.reqack;
    assign r0.respcyc = resp_phase && !owner && bus.respcyc;
    assign r1.respcyc = resp_phase &&  owner && bus.respcyc;
    assign r0.resp    = bus.resp;
    assign r1.resp    = bus.resp;

    assign req_xfer = bus.reqcyc && bus.reqack;
    assign cnt_inc  = beat_cnt + CNT_W'(1);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= 1'b1;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (r0.reqcyc || r1.reqcyc) begin
                        // Contention goes to whoever did not own the bus last.
                        owner <= (r0.reqcyc && r1.reqcyc) ? ~owner : r1.reqcyc;
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (req_xfer) begin
                        beat_cnt <= '0;
                        state    <= own_tag[TAG_W-1] ? S_WDATA : S_RESP;
                    end else if (!own_reqcyc) begin
                        state <= S_IDLE;
                    end
                end
                S_WDATA: begin
                    if (req_xfer) begin
                        beat_cnt <= cnt_inc;
                        if (cnt_inc == LAST_BEAT) state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    if (bus.respack) begin
                        beat_cnt <= cnt_inc;
                        if (cnt_inc == LAST_BEAT) state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A response beat with no read outstanding is dropped; flag it in simulation.
    always_ff @(posedge clk) begin
        if (!reset)
            assert (!(bus.respcyc && !resp_phase))
            else $warning("sysbus_arbiter: stray response beat outside RESP dropped");
    end
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed + randomized bench for sysbus_arbiter; grant order comes from a
// last-owner round-robin model, beat streams from per-transaction tables.
module tb_sysbus_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic owner, busy;

  sysbus_arbiter_if #(.DATA_W(64), .TAG_W(13)) r0_if ();
  sysbus_arbiter_if #(.DATA_W(64), .TAG_W(13)) r1_if ();
  sysbus_arbiter_if #(.DATA_W(64), .TAG_W(13)) bus_if ();

  sysbus_arbiter #(.DATA_W(64), .TAG_W(13), .LINE_BEATS(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .r0(r0_if), .r1(r1_if), .bus(bus_if),
    .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // reference state: who owned the bus last, and each requester's pending transaction
  bit          last_owner;
  bit          pend [2];
  logic [63:0] addr [2];
  logic [12:0] tag  [2];
  logic [63:0] wdat [2][8];
  logic [63:0] rdat [8];
  int          last_rsp_cycles;
  logic [9:0]  bp_pat = 10'b1111110011;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_req(input bit p, input logic c, input logic [63:0] d, input logic [12:0] t);
    if (p) begin r1_if.reqcyc = c; r1_if.req = d; r1_if.reqtag = t; end
    else   begin r0_if.reqcyc = c; r0_if.req = d; r0_if.reqtag = t; end
  endtask

  task automatic set_respack(input bit p, input logic v);
    if (p) r1_if.respack = v; else r0_if.respack = v;
  endtask

  function automatic logic ack_of(input bit p);
    return p ? r1_if.reqack : r0_if.reqack;
  endfunction
  function automatic logic rcyc_of(input bit p);
    return p ? r1_if.respcyc : r0_if.respcyc;
  endfunction
  function automatic logic [63:0] resp_of(input bit p);
    return p ? r1_if.resp : r0_if.resp;
  endfunction

  task automatic new_txn(input bit p, input bit wr);
    pend[p] = 1'b1;
    addr[p] = {$urandom, $urandom};
    tag[p]  = {wr, 12'($urandom)};
    for (int i = 0; i < 8; i++) wdat[p][i] = {$urandom, $urandom};
    if (!wr) for (int i = 0; i < 8; i++) rdat[i] = {$urandom, $urandom};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 0, 0, 0); set_req(1, 0, 0, 0);
    set_respack(0, 0); set_respack(1, 0);
    bus_if.reqack = 0; bus_if.respcyc = 0; bus_if.resp = 0;
    tick(); tick();
    reset = 1'b0;
    last_owner = 1'b1;
    pend[0] = 0; pend[1] = 0;
  endtask

  // Runs one transaction from an IDLE cycle. mode 0: bus always ready,
  // 1: fixed respack stall pattern, 2: random stalls. abort_at>=0 leaves it in RESP.
  task automatic serve(input int mode, input int abort_at, output bit g);
    int n, acc;
    logic rpk;
    for (int p = 0; p < 2; p++) set_req(p[0], pend[p], addr[p], tag[p]);
    bus_if.reqack = 0; bus_if.respcyc = 0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_bus_reqcyc", bus_if.reqcyc, 0);
    chk("idle_no_reqack", {r1_if.reqack, r0_if.reqack}, 0);
    g = (pend[0] && pend[1]) ? !last_owner : pend[1];
    last_owner = g;
    pend[g] = 0;
    tick();
    chk("grant_owner", owner, g);
    chk("grant_busy", busy, 1);
    n = 0; acc = 0;
    while (!acc && n < 50) begin
      bus_if.reqack = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      chk("req_cyc", bus_if.reqcyc, 1);
      chk("req_addr", bus_if.req, addr[g]);
      chk("req_tag", bus_if.reqtag, tag[g]);
      chk("req_ack", ack_of(g), bus_if.reqack);
      chk("req_other_ack", ack_of(!g), 0);
      acc = bus_if.reqack;
      tick(); n++;
    end
    if (!acc) chk("req_timeout", 0, 1);
    if (tag[g][12]) begin
      acc = 0; n = 0;
      while (acc < 8 && n < 100) begin
        set_req(g, 1, wdat[g][acc], tag[g]);
        bus_if.reqack = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
        #1;
        chk("wr_busy", busy, 1);
        chk("wr_beat", bus_if.req, wdat[g][acc]);
        chk("wr_ack", ack_of(g), bus_if.reqack);
        chk("wr_other_ack", ack_of(!g), 0);
        if (bus_if.reqack) acc++;
        tick(); n++;
      end
      if (acc < 8) chk("wr_timeout", 0, 1);
      set_req(g, 0, 0, 0); bus_if.reqack = 0;
      chk("wr_done_busy", busy, 0);
    end else begin
      set_req(g, 0, 0, 0); bus_if.reqack = 0;
      acc = 0; n = 0;
      while (acc < 8 && n < 200) begin
        if (acc == abort_at) return;
        bus_if.respcyc = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus_if.resp = rdat[acc];
        rpk = (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 1 && n < 10) ? bp_pat[n] : 1'b1;
        set_respack(g, rpk);
        #1;
        chk("rsp_busy", busy, 1);
        chk("rsp_cyc", rcyc_of(g), bus_if.respcyc);
        chk("rsp_other_cyc", rcyc_of(!g), 0);
        chk("rsp_data", resp_of(g), rdat[acc]);
        chk("rsp_ack", bus_if.respack, bus_if.respcyc & rpk);
        chk("rsp_bus_reqcyc", bus_if.reqcyc, 0);
        if (bus_if.respcyc && rpk) acc++;
        tick(); n++;
      end
      if (acc < 8) chk("rsp_timeout", 0, 1);
      bus_if.respcyc = 0; set_respack(g, 0);
      last_rsp_cycles = n;
      chk("rsp_done_busy", busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit g;
    do_reset();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    chk("rst_bus_reqcyc", bus_if.reqcyc, 0);
    chk("rst_bus_req", bus_if.req, 0);
    chk("rst_bus_reqtag", bus_if.reqtag, 0);
    chk("rst_bus_respack", bus_if.respack, 0);
    chk("rst_reqack", {r1_if.reqack, r0_if.reqack}, 0);
    chk("rst_respcyc", {r1_if.respcyc, r0_if.respcyc}, 0);

    // fetch read alone at 0x1000, responses A0..A7
    new_txn(0, 0);
    addr[0] = 64'h1000; tag[0] = 13'h0;
    for (int i = 0; i < 8; i++) rdat[i] = 64'hA0 + 64'(i);
    serve(0, -1, g);

    // simultaneous requests after reset: r0, r1, then r0 again
    do_reset();
    new_txn(0, 0); new_txn(1, 0);
    serve(0, -1, g);
    serve(0, -1, g);
    new_txn(0, 0); new_txn(1, 0);
    serve(0, -1, g);
    pend[1] = 0;

    // data write to 0x2040, beats 0x11..0x88
    new_txn(1, 1);
    addr[1] = 64'h2040;
    for (int i = 0; i < 8; i++) wdat[1][i] = 64'h11 * 64'(i + 1);
    serve(0, -1, g);

    // owner withdraws before its address is taken
    set_req(0, 1, 64'h3000, 13'h0); bus_if.reqack = 0;
    tick();
    chk("drop_owner", owner, 0);
    chk("drop_busy", busy, 1);
    set_req(0, 0, 0, 0);
    #1;
    chk("drop_bus_reqcyc", bus_if.reqcyc, 0);
    tick();
    chk("drop_idle", busy, 0);
    last_owner = 0;

    // response backpressure on beats 3-4
    new_txn(0, 0);
    serve(1, -1, g);
    chk("bp_rsp_cycles", last_rsp_cycles, 10);

    // reset after 4 response beats, with beats still arriving
    new_txn(0, 0);
    serve(0, 4, g);
    reset = 1'b1; bus_if.respcyc = 1'b1; set_respack(0, 1);
    tick();
    reset = 1'b0;
    last_owner = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 1);
    chk("mid_rst_respcyc", {r1_if.respcyc, r0_if.respcyc}, 0);
    chk("mid_rst_respack", bus_if.respack, 0);
    chk("mid_rst_bus_reqcyc", bus_if.reqcyc, 0);
    chk("mid_rst_reqack", {r1_if.reqack, r0_if.reqack}, 0);
    tick();
    bus_if.respcyc = 0; set_respack(0, 0);
    new_txn(1, 0);
    serve(0, -1, g);

    // stray response beat while idle
    bus_if.respcyc = 1'b1; bus_if.resp = 64'hDEAD; set_respack(0, 1); set_respack(1, 1);
    #1;
    chk("stray_respcyc", {r1_if.respcyc, r0_if.respcyc}, 0);
    chk("stray_respack", bus_if.respack, 0);
    chk("stray_busy", busy, 0);
    tick();
    bus_if.respcyc = 0; set_respack(0, 0); set_respack(1, 0);

    // randomized traffic with stalls; unserved requesters keep asking
    for (int k = 0; k < 24; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1) new_txn(p[0], $urandom_range(0, 1) == 1);
      if (!pend[0] && !pend[1]) new_txn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      serve(2, -1, g);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
